// File: rtl/usb_rx_pkt_commit_fifo.sv
// RX packet FIFO with speculative writes: bytes become readable only after a
// packet commit; an abort (or a commit after overflow) rolls the writer back.
module usb_rx_pkt_commit_fifo #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_pkt_commit,
  input  logic          i_pkt_abort,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_valid,
  output logic [AW:0]   o_level,
  output logic [AW:0]   o_free,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_pkt_drop
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  logic [AW:0]   r_wp;
  logic [AW:0]   r_cp;
  logic [AW:0]   r_rp;
  logic          r_ovf;
  logic          r_drop;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic [AW:0]   r_level;
  logic [AW:0]   r_free;

  logic          w_full;
  logic          w_empty;
  logic          w_lost;
  logic          w_ovf_now;
  logic          w_abort;
  logic          w_commit;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW:0]   w_wp_next;

  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_empty   = (r_cp == r_rp);

  // A byte lost in the same cycle as the commit still poisons that commit.
  assign w_lost    = i_wr_en && w_full;
  assign w_ovf_now = r_ovf || w_lost;
  assign w_abort   = i_pkt_abort || (i_pkt_commit && w_ovf_now);
  assign w_commit  = i_pkt_commit && !w_abort;
  assign w_wr_ok   = i_wr_en && !w_full && !w_abort;
  assign w_rd_ok   = i_rd_en && !w_empty;
  assign w_wp_next = w_abort ? r_cp : (r_wp + {{AW{1'b0}}, w_wr_ok});

  always_ff @(posedge CLK) begin
    if (w_wr_ok) begin
      r_mem[r_wp[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wp   <= '0;
      r_cp   <= '0;
      r_ovf  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_wp   <= w_wp_next;
      r_ovf  <= w_abort ? 1'b0 : w_ovf_now;
      r_drop <= w_abort;
      if (w_commit) begin
        r_cp <= w_wp_next;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rp       <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rp[AW-1:0]];
        r_rp      <= r_rp + 1'b1;
      end
    end
  end

  // Counts are taken from the current pointers, so they trail pointer moves by one cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_level <= '0;
      r_free  <= DEPTH;
    end else begin
      r_level <= r_cp - r_rp;
      r_free  <= DEPTH - (r_wp - r_rp);
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_level    = r_level;
  assign o_free     = r_free;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_pkt_drop = r_drop;

endmodule

// File: tb/tb_usb_rx_pkt_commit_fifo.sv
// Bench for usb_rx_pkt_commit_fifo (AW=4): queue-based packet model of committed
// and pending bytes, directed scenarios plus a randomized packet stream.
module tb_usb_rx_pkt_commit_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NPKT  = 3 * DEPTH;

  logic          CLK;
  logic          RSTn;
  logic          i_wr_en;
  logic [DW-1:0] i_wr_data;
  logic          i_pkt_commit;
  logic          i_pkt_abort;
  logic          i_rd_en;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic [AW:0]   o_level;
  logic [AW:0]   o_free;
  logic          o_full;
  logic          o_empty;
  logic          o_pkt_drop;

  usb_rx_pkt_commit_fifo #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .i_pkt_commit(i_pkt_commit), .i_pkt_abort(i_pkt_abort),
    .i_rd_en(i_rd_en),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_level(o_level), .o_free(o_free),
    .o_full(o_full), .o_empty(o_empty), .o_pkt_drop(o_pkt_drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: committed bytes in read order, bytes of the packet being received, overflow flag.
  logic [DW-1:0] q_c [$];
  logic [DW-1:0] q_s [$];
  bit            m_ovf;

  logic [DW-1:0] exp_rd_data;
  bit            exp_rd_valid;
  bit            exp_drop;
  bit            exp_empty;
  bit            exp_full;
  int            exp_level;
  int            exp_free;

  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    q_c.delete();
    q_s.delete();
    m_ovf        = 1'b0;
    exp_rd_data  = '0;
    exp_rd_valid = 1'b0;
    exp_drop     = 1'b0;
    exp_empty    = 1'b1;
    exp_full     = 1'b0;
    exp_level    = 0;
    exp_free     = DEPTH;
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit cm, input bit ab, input bit re);
    int occ;
    bit was_full;
    bit lost;
    i_wr_en      = we;
    i_wr_data    = wd;
    i_pkt_commit = cm;
    i_pkt_abort  = ab;
    i_rd_en      = re;
    occ       = q_c.size() + q_s.size();
    was_full  = (occ == DEPTH);
    exp_level = q_c.size();
    exp_free  = DEPTH - occ;
    if (re && q_c.size() > 0) begin
      exp_rd_data  = q_c.pop_front();
      exp_rd_valid = 1'b1;
    end else begin
      exp_rd_valid = 1'b0;
    end
    lost = we && was_full;
    if (ab || (cm && (m_ovf || lost))) begin
      q_s.delete();
      m_ovf    = 1'b0;
      exp_drop = 1'b1;
    end else begin
      exp_drop = 1'b0;
      if (we && !was_full) q_s.push_back(wd);
      if (lost) m_ovf = 1'b1;
      if (cm) begin
        foreach (q_s[k]) q_c.push_back(q_s[k]);
        q_s.delete();
      end
    end
    exp_empty = (q_c.size() == 0);
    exp_full  = ((q_c.size() + q_s.size()) == DEPTH);
    @(posedge CLK);
    #1;
    i_wr_en      = 1'b0;
    i_pkt_commit = 1'b0;
    i_pkt_abort  = 1'b0;
    i_rd_en      = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    i_wr_en = 1'b0; i_wr_data = '0; i_pkt_commit = 1'b0; i_pkt_abort = 1'b0; i_rd_en = 1'b0;
    model_clear();
    #12;
    checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b want 1 0", o_empty, o_full); end
    checks++; if (o_level !== 5'd0 || o_free !== 5'(DEPTH)) begin errors++; $display("FAIL reset_counts level=%0d free=%0d want 0 %0d", o_level, o_free, DEPTH); end
    checks++; if (o_rd_data !== 8'h00 || o_rd_valid !== 1'b0 || o_pkt_drop !== 1'b0) begin errors++; $display("FAIL reset_out rd_data=%h rd_valid=%b drop=%b want 00 0 0", o_rd_data, o_rd_valid, o_pkt_drop); end
    @(negedge CLK);
    RSTn = 1'b1;
    step(0, 0, 0, 0, 1);
    checks++; if (o_rd_valid !== 1'b0 || o_empty !== 1'b1 || o_free !== 5'(exp_free)) begin errors++; $display("FAIL reset_idle rd_valid=%b empty=%b free=%0d want 0 1 %0d", o_rd_valid, o_empty, o_free, exp_free); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [DW-1:0] bytes [3];
    bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3;
    for (int i = 0; i < 3; i++) step(1, bytes[i], 0, 0, 0);
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL basic_precommit_empty empty=%b want 1", o_empty); end
    step(0, 0, 1, 0, 0);
    checks++; if (o_empty !== 1'b0 || o_pkt_drop !== 1'b0) begin errors++; $display("FAIL basic_commit empty=%b drop=%b want 0 0", o_empty, o_pkt_drop); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== bytes[i]) begin errors++; $display("FAIL basic_read%0d valid=%b data=%h want 1 %h", i, o_rd_valid, o_rd_data, bytes[i]); end
      $display("basic read %0d data=%h", i, o_rd_data);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (o_level !== 5'd0 || o_empty !== 1'b1 || o_rd_valid !== 1'b0) begin errors++; $display("FAIL basic_drained level=%0d empty=%b valid=%b want 0 1 0", o_level, o_empty, o_rd_valid); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (o_empty !== 1'b1 || o_level !== 5'd0 || o_free !== 5'(DEPTH - 5)) begin errors++; $display("FAIL abort_pending empty=%b level=%0d free=%0d want 1 0 %0d", o_empty, o_level, o_free, DEPTH - 5); end
    step(0, 0, 0, 1, 0);
    checks++; if (o_pkt_drop !== 1'b1) begin errors++; $display("FAIL abort_drop drop=%b want 1", o_pkt_drop); end
    step(0, 0, 0, 0, 0);
    checks++; if (o_pkt_drop !== 1'b0 || o_free !== 5'(DEPTH) || o_empty !== 1'b1) begin errors++; $display("FAIL abort_after drop=%b free=%0d empty=%b want 0 %0d 1", o_pkt_drop, o_free, o_empty, DEPTH); end
    $display("test_abort done");
  endtask

  task automatic test_abort_during_read();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 8'(8'h20 + i), 0, 0, i >= 3);
      if (i >= 3) begin
        checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_rd_data) begin errors++; $display("FAIL p1_read valid=%b data=%h want 1 %h", o_rd_valid, o_rd_data, exp_rd_data); end
      end
    end
    step(0, 0, 0, 1, 1);
    checks++; if (o_rd_data !== 8'h13 || o_pkt_drop !== 1'b1) begin errors++; $display("FAIL p1_last_abort data=%h drop=%b want 13 1", o_rd_data, o_pkt_drop); end
    step(1, 8'h31, 0, 0, 0);
    step(1, 8'h32, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 1);
      checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'(8'h31 + i)) begin errors++; $display("FAIL p3_read%0d valid=%b data=%h want 1 %h", i, o_rd_valid, o_rd_data, 8'(8'h31 + i)); end
    end
    step(0, 0, 0, 0, 1);
    checks++; if (o_rd_valid !== 1'b0 || o_rd_data !== 8'h32) begin errors++; $display("FAIL empty_read valid=%b data=%h want 0 32", o_rd_valid, o_rd_data); end
    $display("test_abort_during_read done");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ovf_full full=%b want 1", o_full); end
    step(0, 0, 1, 0, 0);
    checks++; if (o_pkt_drop !== 1'b1 || o_level !== 5'd0 || o_empty !== 1'b1) begin errors++; $display("FAIL ovf_commit drop=%b level=%0d empty=%b want 1 0 1", o_pkt_drop, o_level, o_empty); end
    step(0, 0, 0, 0, 0);
    checks++; if (o_free !== 5'(DEPTH) || o_full !== 1'b0) begin errors++; $display("FAIL ovf_free free=%0d full=%b want %0d 0", o_free, o_full, DEPTH); end
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'hC0 + i), i == DEPTH - 1, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (o_level !== 5'(DEPTH) || o_empty !== 1'b0 || o_full !== 1'b1 || o_free !== 5'd0) begin errors++; $display("FAIL fulldepth level=%0d empty=%b full=%b free=%0d want %0d 0 1 0", o_level, o_empty, o_full, o_free, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0, 1);
      checks++; if (o_rd_data !== 8'(8'hC0 + i)) begin errors++; $display("FAIL fulldepth_read%0d data=%h want %h", i, o_rd_data, 8'(8'hC0 + i)); end
    end
    $display("test_overflow done");
  endtask

  task automatic test_same_cycle();
    step(1, 8'h61, 0, 0, 0);
    step(1, 8'h62, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h62) begin errors++; $display("FAIL wr_commit_last data=%h valid=%b want 62 1", o_rd_data, o_rd_valid); end
    step(1, 8'h71, 0, 0, 0);
    step(1, 8'h72, 0, 1, 0);
    step(1, 8'h73, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h73) begin errors++; $display("FAIL wr_abort_discard data=%h valid=%b want 73 1", o_rd_data, o_rd_valid); end
    step(0, 0, 0, 0, 1);
    checks++; if (o_rd_valid !== 1'b0 || o_empty !== 1'b1) begin errors++; $display("FAIL wr_abort_empty valid=%b empty=%b want 0 1", o_rd_valid, o_empty); end
    $display("test_same_cycle done");
  endtask

  task automatic test_random();
    int  done_pkts = 0;
    int  left = 0;
    int  len;
    bit  active = 0;
    bit  do_abort = 0;
    bit  we, cm, ab, re;
    logic [DW-1:0] wd;
    int  cyc = 0;
    while ((done_pkts < NPKT || q_c.size() > 0 || active) && cyc < 6000) begin
      cyc++;
      we = 0; cm = 0; ab = 0; wd = '0;
      if (!active && done_pkts < NPKT) begin
        len = $urandom_range(1, DEPTH / 2);
        if (DEPTH - (q_c.size() + q_s.size()) >= len) begin
          active   = 1;
          left     = len;
          do_abort = ($urandom_range(0, 7) == 0);
        end
      end
      if (active) begin
        if (left == 0) begin
          ab = do_abort; cm = !do_abort; active = 0; done_pkts++;
        end else if ($urandom_range(0, 3) != 0) begin
          we = 1; wd = 8'($urandom); left--;
          if (left == 0 && $urandom_range(0, 1) == 1) begin
            ab = do_abort; cm = !do_abort; active = 0; done_pkts++;
          end
        end
      end
      re = active ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      step(we, wd, cm, ab, re);
      checks++;
      if (o_rd_valid !== exp_rd_valid || o_rd_data !== exp_rd_data || o_pkt_drop !== exp_drop ||
          o_empty !== exp_empty || o_full !== exp_full || o_level !== 5'(exp_level) || o_free !== 5'(exp_free) ||
          (int'(o_level) + int'(o_free)) > DEPTH) begin
        errors++;
        $display("FAIL rand_cyc%0d valid=%b data=%h drop=%b empty=%b full=%b level=%0d free=%0d want %b %h %b %b %b %0d %0d",
                 cyc, o_rd_valid, o_rd_data, o_pkt_drop, o_empty, o_full, o_level, o_free,
                 exp_rd_valid, exp_rd_data, exp_drop, exp_empty, exp_full, exp_level, exp_free);
      end
    end
    checks++;
    if (done_pkts != NPKT || q_c.size() != 0) begin
      errors++;
      $display("FAIL rand_timeout packets=%0d pending=%0d want %0d 0", done_pkts, q_c.size(), NPKT);
    end
    $display("test_random done packets=%0d cycles=%0d", done_pkts, cyc);
  endtask

  task automatic test_reset_mid_packet();
    for (int i = 0; i < 3; i++) step(1, 8'(8'hE0 + i), i == 2, 0, 0);
    step(1, 8'hE8, 0, 0, 0);
    step(1, 8'hE9, 0, 0, 1);
    @(negedge CLK);
    RSTn = 1'b0;
    model_clear();
    #1;
    checks++; if (o_empty !== 1'b1 || o_level !== 5'd0 || o_free !== 5'(DEPTH) || o_rd_data !== 8'h00 || o_rd_valid !== 1'b0) begin errors++; $display("FAIL midreset empty=%b level=%0d free=%0d data=%h valid=%b want 1 0 %0d 00 0", o_empty, o_level, o_free, o_rd_data, o_rd_valid, DEPTH); end
    @(negedge CLK);
    RSTn = 1'b1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    checks++; if (o_rd_valid !== 1'b0 || o_empty !== 1'b1 || o_pkt_drop !== 1'b0) begin errors++; $display("FAIL midreset_after valid=%b empty=%b drop=%b want 0 1 0", o_rd_valid, o_empty, o_pkt_drop); end
    $display("test_reset_mid_packet done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_abort_during_read();
    test_overflow();
    test_same_cycle();
    test_random();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
